// File: rtl/fan_schedule_ctrl.sv
// fan_schedule_ctrl
//   Per-cycle configuration sequencer for a row of forwarding adder switches.
//   Holds a DEPTH-entry schedule (add_en, cmd[2:0], sel per switch, switch 0
//   in the LSBs) and plays it out one entry per cycle after a start pulse,
//   honouring i_stall, then drains for DRAIN_CYC cycles and pulses o_done.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   cfg_wr_*        schedule write port (accepted only while idle)
//   start           one-cycle playback request; num_steps sampled with it
//   i_stall         hold playback for this cycle
//   o_busy, o_done  playback/drain in progress; one-cycle completion pulse
//   o_valid, o_add_en, o_cmd, o_sel, o_step   registered switch controls
//   o_cfg_err       sticky illegal-entry flag
//
// Build option
//   FAN_SCHED_CMD_CHECK_EN  enables the per-switch entry checker driving
//                           o_cfg_err; otherwise o_cfg_err is constant 0.
module fan_schedule_ctrl #(
  parameter int NUM_ADDERS = 8,
  parameter int SEL_IN     = 2,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int DRAIN_CYC  = 1,
  parameter int ENTRY_W    = NUM_ADDERS * (4 + SEL_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr_en,
  input  logic [ADDR_W-1:0]            cfg_wr_addr,
  input  logic [ENTRY_W-1:0]           cfg_wr_data,
  input  logic                         start,
  input  logic [ADDR_W:0]              num_steps,
  input  logic                         i_stall,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_valid,
  output logic [NUM_ADDERS-1:0]        o_add_en,
  output logic [3*NUM_ADDERS-1:0]      o_cmd,
  output logic [SEL_IN*NUM_ADDERS-1:0] o_sel,
  output logic [ADDR_W-1:0]            o_step,
  output logic                         o_cfg_err
);

  localparam int FW  = 4 + SEL_IN;
  localparam int DCW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                        state;
  logic [ENTRY_W-1:0]            mem [DEPTH];
  logic [ADDR_W-1:0]             step;
  logic [ADDR_W:0]               n_lat;
  logic [DCW-1:0]                drain_cnt;

  logic [ADDR_W:0]               n_clip;
  logic                          last_issue;
  logic [NUM_ADDERS-1:0]         rd_add;
  logic [3*NUM_ADDERS-1:0]       rd_cmd;
  logic [SEL_IN*NUM_ADDERS-1:0]  rd_sel;

  // Schedule memory: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_wr_en)
      mem[cfg_wr_addr] <= cfg_wr_data;
  end

  always_comb begin
    n_clip = (num_steps > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_steps;
    last_issue = ({1'b0, step} == n_lat - 1'b1);
  end

  always_comb begin
    rd_add = '0;
    rd_cmd = '0;
    rd_sel = '0;
    for (int unsigned k = 0; k < NUM_ADDERS; k++) begin
      rd_sel[k*SEL_IN +: SEL_IN] = mem[step][k*FW +: SEL_IN];
      rd_cmd[k*3 +: 3]           = mem[step][k*FW + SEL_IN +: 3];
      rd_add[k]                  = mem[step][k*FW + SEL_IN + 3];
    end
  end

  // Outputs are loaded from the state being left at each edge, so o_done
  // and o_busy trail the state register by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      n_lat     <= '0;
      drain_cnt <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_valid   <= 1'b0;
      o_add_en  <= '0;
      o_cmd     <= '0;
      o_sel     <= '0;
      o_step    <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_valid  <= 1'b0;
          o_add_en <= '0;
          o_done   <= 1'b0;
          o_busy   <= 1'b0;
          if (start) begin
            n_lat  <= n_clip;
            step   <= '0;
            o_busy <= 1'b1;
            state  <= (n_clip == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          o_busy <= 1'b1;
          if (!i_stall) begin
            o_valid  <= 1'b1;
            o_add_en <= rd_add;
            o_cmd    <= rd_cmd;
            o_sel    <= rd_sel;
            o_step   <= step;
            step     <= step + 1'b1;
            if (last_issue) begin
              drain_cnt <= DCW'(DRAIN_CYC);
              state     <= (DRAIN_CYC == 0) ? DONE : DRAIN;
            end
          end else begin
            o_valid <= 1'b0;
          end
        end
        DRAIN: begin
          o_valid  <= 1'b0;
          o_add_en <= '0;
          o_cmd    <= '0;
          if (drain_cnt <= DCW'(1)) begin
            drain_cnt <= '0;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          o_valid  <= 1'b0;
          o_add_en <= '0;
          o_cmd    <= '0;
          o_done   <= 1'b1;
          o_busy   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FAN_SCHED_CMD_CHECK_EN
  function automatic logic entry_bad(input logic [ENTRY_W-1:0] e);
    logic       bad;
    logic [2:0] c;
    bad = 1'b0;
    for (int unsigned k = 0; k < NUM_ADDERS; k++) begin
      c = e[k*FW + SEL_IN +: 3];
      if (c[2:1] == 2'b11) bad = 1'b1;
      if (e[k*FW + SEL_IN + 3] && c != 3'b000 && c != 3'b010) bad = 1'b1;
    end
    return bad;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      o_cfg_err <= 1'b0;
    else if (state == IDLE && start)
      o_cfg_err <= 1'b0;
    else if (state == RUN && !i_stall && entry_bad(mem[step]))
      o_cfg_err <= 1'b1;
  end
`else
  assign o_cfg_err = 1'b0;
`endif

endmodule

// File: doc/fan_schedule_ctrl.md
Name: fan_schedule_ctrl

Overview:
- Per-cycle configuration sequencer for a row of NUM_ADDERS forwarding adder switches in the reduction network.
- Stores a schedule of NUM_STEPS-deep configuration entries, each holding add_en, cmd[2:0] and sel for every switch.
- On start, plays the schedule out one entry per cycle, with valid, stall and drain handling.
- Reports completion to the top-level controller.

Parameters:
- NUM_ADDERS, 8, number of adder switches driven.
- SEL_IN, 2, width of each switch's reduction-mux select.
- DEPTH, 16, schedule entries stored.
- ADDR_W, 4, log2(DEPTH).
- DRAIN_CYC, 1, cycles waited after the last entry so switch output registers settle.
- ENTRY_W, NUM_ADDERS*(4+SEL_IN), derived width of one entry. Per-switch field k is {add_en, cmd[2:0], sel}, with switch 0 in the LSBs.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_wr_en  in  1  schedule write strobe
- cfg_wr_addr  in  ADDR_W  entry index to write
- cfg_wr_data  in  ENTRY_W  entry contents
- start  in  1  begin playback, one-cycle pulse
- num_steps  in  ADDR_W+1  entries to play, sampled with start
- i_stall  in  1  hold playback this cycle
- o_busy  out  1  playback or drain in progress
- o_done  out  1  one-cycle completion pulse
- o_valid  out  1  valid to all switches
- o_add_en  out  NUM_ADDERS  per-switch add enable
- o_cmd  out  3*NUM_ADDERS  per-switch command
- o_sel  out  SEL_IN*NUM_ADDERS  per-switch mux select
- o_step  out  ADDR_W  index of the entry currently driven
- o_cfg_err  out  1  sticky illegal-entry flag (see Optional Feature)

Behaviour:
- Reset:
  - All outputs are 0 and state is IDLE; step and drain counters are 0.
  - Schedule memory is not reset and retains its contents.
- Reset mid-playback aborts immediately. No o_done is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - A cfg_wr_en write commits at the clock edge.
  - start=1 latches n = min(num_steps, DEPTH).
  - If n=0, go to DONE. Otherwise go to RUN with step=0.
- A write and start in the same cycle are both honoured. Playback sees the new data because the memory is read one cycle later.
- Writes are ignored outside IDLE, and start is ignored outside IDLE.
- RUN, output registers loaded each edge:
  - If i_stall=0: o_valid=1; o_add_en/o_cmd/o_sel=mem[step]; o_step=step; step increments.
  - If i_stall=1: o_valid=0; fields and o_step hold; step holds.
  - After the edge that issues entry n-1, go to DRAIN with drain counter = DRAIN_CYC.
- Latency: start sampled at edge E0 gives the first o_valid during the cycle after edge E1. With no stalls, n valid cycles are back-to-back.
- DRAIN:
  - o_valid=0; o_add_en is forced to 0; o_cmd=000.
  - Counts down one per cycle. At 0, go to DONE.
  - DRAIN_CYC=0 goes straight to DONE.
- DONE: o_done=1 for exactly one cycle, then go to IDLE.
- o_busy=1 in RUN, DRAIN and DONE; 0 in IDLE.
- i_stall is ignored in DRAIN and DONE.
- In IDLE, o_valid=0 and o_add_en=0. o_cmd/o_sel hold their last values.

Optional Feature:
- Macro: FAN_SCHED_CMD_CHECK_EN.
- When defined, each issued entry is checked per switch. The check flags:
  - cmd in {110, 111};
  - add_en=1 with cmd other than 000 or 010.
- A violation sets o_cfg_err=1 on the same edge the entry is issued. The flag stays set until the next start in IDLE or rst.
- The entry is still issued unchanged.
- Without the macro, o_cfg_err is tied to 0 and no checker logic exists.

Test Plan:
- Basic playback: write entries 0..3 with distinct patterns, num_steps=4, start at E0. Expect:
  - o_valid high during cycles E1..E4 with mem[0..3] and o_step 0..3;
  - o_valid=0 and o_add_en=0 in DRAIN;
  - o_done pulse one cycle after drain; o_busy high from E0+1 through the done cycle.
- Stall: num_steps=3, i_stall high on the edge after the first issue. Expect o_valid pattern 1,0,1,1 with entries 0,0(held),1,2; o_done one cycle after the 1-cycle drain following the last issue.
- Boundaries:
  - num_steps=0: o_done pulses 2 cycles after start, no o_valid.
  - num_steps=31 with DEPTH=16: exactly 16 entries issued, step wraps cleanly, no extra.
- Illegal requests while busy: start and cfg_wr_en during RUN are ignored. Readback via a second playback shows the memory unchanged and no restart.
- Reset mid-RUN at entry 2: next cycle all outputs are 0, no o_done. A new start replays from entry 0 using the retained memory.
- Checker (macro on): entry 1 has switch 3 cmd=111. Expect o_cfg_err rising on entry 1's issue edge, staying set, clearing on the next start. With the macro off, o_cfg_err stays 0.
